lfsr_decrypt_engine: RTL and testbench

LFSR_DECRYPT_ENGINE -- requirements
Module: lfsr_decrypt_engine

---
 rtl/lfsr_pkg.sv | 36 +++
 rtl/lfsr_step.sv | 19 +
 rtl/lfsr_decrypt_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_lfsr_decrypt_engine.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared types and constants for the LFSR decrypt engine:
//                FSM state encoding, default tap-pattern table and the ASCII
//                offset added to every recovered plaintext byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int c_def_lw     = 7;
  localparam int c_def_n_ptrn = 9;

  // Entry 0 sits in the low bits, so c_taps_default[0] == 7'h60.
  localparam logic [c_def_n_ptrn-1:0][c_def_lw-1:0] c_taps_default = {
    7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
  };

  // Plaintext is transported as (character - space), so space is added back.
  localparam logic [7:0] c_ascii_ofs = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_DETECT  = 3'd2,
    ST_DECRYPT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_step
//  Description : Combinational one-step advance of a Fibonacci-style LFSR.
//                Shifts left and feeds the tapped parity into bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step #(
  parameter int LW = 7
) (
  input  logic [LW-1:0] state_i,
  input  logic [LW-1:0] taps_i,
  output logic [LW-1:0] next_o
);

  assign next_o = {state_i[LW-2:0], ^(state_i & taps_i)};

endmodule
`default_nettype wire

// File: rtl/lfsr_decrypt_engine.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_decrypt_engine
//  Description : Streaming decryptor for LFSR-encrypted 7-bit text. Byte 0
//                carries the seed, the following preamble bytes (plain
//                spaces) identify which of N_PTRN tap patterns is in use,
//                and the rest of the message is XOR-decrypted with that
//                pattern's keystream. One plaintext byte per cipher byte,
//                single-entry output register with ready/valid back-pressure.
//  Options     : define LFSR_PARITY_CHECK_EN to build the per-byte parity
//                checker (par_err / err_cnt); otherwise both read zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_decrypt_engine
  import lfsr_pkg::*;
#(
  parameter int                          LW      = 7,
  parameter int                          N_PTRN  = 9,
  parameter int                          MSG_LEN = 64,
  parameter int                          PRE_LEN = 10,
  parameter logic [N_PTRN-1:0][LW-1:0]   TAPS    = c_taps_default,
  localparam int                         PW      = idx_width(N_PTRN),
  localparam int                         EW      = $clog2(MSG_LEN + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW:0]   out_data,
  output logic          Ack,
  output logic [PW-1:0] ptrn_idx,
  output logic [LW-1:0] seed,
  output logic          no_match,
  output logic          par_err,
  output logic [EW-1:0] err_cnt
);

  localparam int         CW    = $clog2(MSG_LEN);
  localparam logic [LW:0] c_ofs = (LW + 1)'(c_ascii_ofs);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        cand_q [N_PTRN];
  logic [LW-1:0]        cand_d [N_PTRN];
  logic [N_PTRN-1:0]    alive_q, alive_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [LW-1:0]        seed_q, seed_d;
  logic                 no_match_q, no_match_d;
  logic                 out_valid_q, out_valid_d;
  logic [LW:0]          out_data_q, out_data_d;

  logic [LW-1:0]        w_next [N_PTRN];
  logic [N_PTRN-1:0]    w_match;
  logic [N_PTRN-1:0]    w_live;
  logic [PW-1:0]        w_low_idx;
  logic                 w_any;
  logic                 w_active;
  logic                 w_xfer;
  logic [LW-1:0]        w_key;

  // One next-state generator per candidate pattern; a candidate survives a
  // preamble byte only when its stepped state equals the received data bits.
  generate
    for (genvar k = 0; k < N_PTRN; k++) begin : g_step
      lfsr_step #(.LW(LW)) u_step (
        .state_i (cand_q[k]),
        .taps_i  (TAPS[k]),
        .next_o  (w_next[k])
      );
      assign w_match[k] = (w_next[k] == in_data[LW-1:0]);
    end
  endgenerate

  assign w_live   = alive_q & w_match;
  assign w_any    = |w_live;
  assign w_active = (state_q == ST_SEED) || (state_q == ST_DETECT) ||
                    (state_q == ST_DECRYPT);
  assign in_ready = Reset && w_active && (!out_valid_q || out_ready);
  assign w_xfer   = in_valid && in_ready;

  // Lowest-index surviving candidate after the current preamble byte.
  always_comb begin
    w_low_idx = '0;
    for (int k = N_PTRN - 1; k >= 0; k--) begin
      if (w_live[k]) w_low_idx = PW'(k);
    end
  end

  // Keystream byte for the current input: the seed itself for byte 0, the
  // leading survivor during detection, the locked pattern afterwards.
  always_comb begin
    case (state_q)
      ST_SEED:   w_key = in_data[LW-1:0];
      ST_DETECT: w_key = w_next[w_low_idx];
      default:   w_key = w_next[idx_q];
    endcase
  end

  // FSM next-state, candidate bookkeeping and output register loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    alive_d     = alive_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    no_match_d  = no_match_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = {1'b0, in_data[LW-1:0] ^ w_key} + c_ofs;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d    = ST_SEED;
          cnt_d      = '0;
          alive_d    = '0;
          no_match_d = 1'b0;
        end
      end
      ST_SEED: begin
        if (w_xfer) begin
          seed_d  = in_data[LW-1:0];
          for (int k = 0; k < N_PTRN; k++) cand_d[k] = in_data[LW-1:0];
          alive_d = '1;
          cnt_d   = CW'(1);
          state_d = ST_DETECT;
        end
      end
      ST_DETECT: begin
        if (w_xfer) begin
          cand_d  = w_next;
          alive_d = w_live;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(PRE_LEN - 1)) begin
            if (w_any) begin
              idx_d   = w_low_idx;
              state_d = ST_DECRYPT;
            end else begin
              no_match_d = 1'b1;
              state_d    = ST_DONE;
            end
          end else if (!w_any) begin
            no_match_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DECRYPT: begin
        if (w_xfer) begin
          cand_d = w_next;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(MSG_LEN - 1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending output byte.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      for (int k = 0; k < N_PTRN; k++) cand_q[k] <= '0;
      alive_q     <= '0;
      idx_q       <= '0;
      seed_q      <= '0;
      no_match_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      alive_q     <= alive_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      no_match_q  <= no_match_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign Ack       = (state_q == ST_DONE);
  assign ptrn_idx  = idx_q;
  assign seed      = seed_q;
  assign no_match  = no_match_q;

`ifdef LFSR_PARITY_CHECK_EN
  logic          par_err_q, par_err_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic          w_par_bad;
  logic          w_restart;

  assign w_par_bad = in_data[LW] ^ (^in_data[LW-1:0]);
  assign w_restart = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Sticky parity flag and saturating error count; cleared on each launch.
  always_comb begin
    par_err_d = par_err_q;
    err_cnt_d = err_cnt_q;
    if (w_restart) begin
      par_err_d = 1'b0;
      err_cnt_d = '0;
    end else if (w_xfer && w_par_bad) begin
      par_err_d = 1'b1;
      if (err_cnt_q != EW'(MSG_LEN)) err_cnt_d = err_cnt_q + EW'(1);
    end
  end

  // Parity status registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      par_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      par_err_q <= par_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign par_err = par_err_q;
  assign err_cnt = err_cnt_q;
`else
  // The parity bit is carried but ignored when the checker is not built.
  logic w_unused_par;
  assign w_unused_par = in_data[LW];
  assign par_err      = 1'b0;
  assign err_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_decrypt_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_decrypt_engine
//  Description : Directed self-checking bench for lfsr_decrypt_engine
//                (LW=7, 9 patterns, 64-byte messages, 15-byte preamble).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_decrypt_engine;

  localparam int MSG_LEN = 64;
  localparam int PRE_LEN = 15;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       Ack;
  logic [3:0] ptrn_idx;
  logic [6:0] seed;
  logic       no_match;
  logic       par_err;
  logic [6:0] err_cnt;

  always #5 Clk = ~Clk;

  lfsr_decrypt_engine #(.PRE_LEN(PRE_LEN)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .Ack       (Ack),
    .ptrn_idx  (ptrn_idx),
    .seed      (seed),
    .no_match  (no_match),
    .par_err   (par_err),
    .err_cnt   (err_cnt)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         n_in  = 0;
  logic [7:0] got [$];
  logic [7:0] msg   [MSG_LEN];
  logic [7:0] plain [MSG_LEN];

  // Record accepted inputs and delivered outputs half a cycle before the edge.
  always @(negedge Clk) begin
    if (Reset && out_valid && out_ready) got.push_back(out_data);
    if (Reset && in_valid && in_ready) n_in++;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void plain_spaces();
    for (int i = 0; i < MSG_LEN; i++) plain[i] = 8'h20;
  endfunction

  function automatic void plain_text();
    string s;
    s = "Mr. Watson, come here.";
    plain_spaces();
    for (int j = 0; j < s.len(); j++) plain[PRE_LEN + j] = s[j];
  endfunction

  // Encrypt plain[] with the given seed and taps into msg[].
  function automatic void build_msg(input logic [6:0] sd, input logic [6:0] tp);
    logic [6:0] s, d, p;
    logic [7:0] diff;
    s = sd;
    for (int i = 0; i < MSG_LEN; i++) begin
      diff   = plain[i] - 8'h20;
      p      = diff[6:0];
      d      = s ^ p;
      msg[i] = {^d, d};
      s      = {s[5:0], ^(s & tp)};
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge Clk);
    while (!in_ready && t < 200) begin
      @(negedge Clk);
      t++;
    end
    ok = in_ready;
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_msg(input int nbytes);
    bit ok;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(msg[i], ok);
      chk_val($sformatf("in_accept%0d", i), 32'(ok), 32'd1);
      if (!ok) break;
      if (i == 0) begin
        chk_val("lat_valid", 32'(out_valid), 32'd1);
        chk_val("lat_data", 32'(out_data), 32'(plain[0]));
      end
    end
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (got.size() < target && t < 200) begin
      @(negedge Clk);
      t++;
    end
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_plain(input int base, input int n);
    chk_val("out_count", 32'(got.size() - base), 32'(n));
    for (int i = 0; i < n && (base + i) < got.size(); i++)
      chk_val($sformatf("byte%0d", i), 32'(got[base + i]), 32'(plain[i]));
  endtask

  task automatic check_cleared(input string tag);
    chk_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk_val({tag, "_ack"},       32'(Ack),       32'd0);
    chk_val({tag, "_no_match"},  32'(no_match),  32'd0);
    chk_val({tag, "_par_err"},   32'(par_err),   32'd0);
    chk_val({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    chk_val({tag, "_ptrn_idx"},  32'(ptrn_idx),  32'd0);
    chk_val({tag, "_seed"},      32'(seed),      32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_in;
    logic [7:0] hold;
    logic exp_pe;
    logic [6:0] exp_ec;

`ifdef LFSR_PARITY_CHECK_EN
    exp_pe = 1'b1;
    exp_ec = 7'd2;
`else
    exp_pe = 1'b0;
    exp_ec = 7'd0;
`endif

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_cleared("rst");
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk_val("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge Clk);
    #1;

    // All-space message, pattern 0x60, seed 0x01
    plain_spaces();
    build_msg(7'h01, 7'h60);
    base = got.size();
    run_msg(MSG_LEN);
    wait_out(base + MSG_LEN);
    check_plain(base, MSG_LEN);
    chk_val("t1_ptrn_idx", 32'(ptrn_idx), 32'd0);
    chk_val("t1_seed", 32'(seed), 32'h01);
    chk_val("t1_ack", 32'(Ack), 32'd1);
    chk_val("t1_no_match", 32'(no_match), 32'd0);
    chk_val("t1_par_err", 32'(par_err), 32'd0);
    chk_val("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk_val("t1_done_in_ready", 32'(in_ready), 32'd0);

    // Text message, pattern 0x48, seed 0x55
    plain_text();
    build_msg(7'h55, 7'h48);
    base = got.size();
    run_msg(MSG_LEN);
    wait_out(base + MSG_LEN);
    check_plain(base, MSG_LEN);
    chk_val("t2_ptrn_idx", 32'(ptrn_idx), 32'd1);
    chk_val("t2_seed", 32'(seed), 32'h55);
    chk_val("t2_ack", 32'(Ack), 32'd1);
    chk_val("t2_no_match", 32'(no_match), 32'd0);

    // Same message with parity flipped on bytes 20 and 40
    msg[20] = msg[20] ^ 8'h80;
    msg[40] = msg[40] ^ 8'h80;
    base = got.size();
    run_msg(MSG_LEN);
    wait_out(base + MSG_LEN);
    check_plain(base, MSG_LEN);
    chk_val("t3_ptrn_idx", 32'(ptrn_idx), 32'd1);
    chk_val("t3_par_err", 32'(par_err), 32'(exp_pe));
    chk_val("t3_err_cnt", 32'(err_cnt), 32'(exp_ec));

    // Byte 2 forced to 0x00: every candidate dies on the third transfer
    plain_spaces();
    build_msg(7'h01, 7'h60);
    msg[2] = 8'h00;
    base = got.size();
    base_in = n_in;
    run_msg(3);
    chk_val("t4_ack", 32'(Ack), 32'd1);
    chk_val("t4_no_match", 32'(no_match), 32'd1);
    chk_val("t4_par_err", 32'(par_err), 32'd0);
    chk_val("t4_err_cnt", 32'(err_cnt), 32'd0);
    in_valid = 1'b1;
    in_data  = msg[3];
    repeat (4) begin
      @(negedge Clk);
      chk_val("t4_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    wait_out(base + 3);
    chk_val("t4_in_count", 32'(n_in - base_in), 32'd3);
    chk_val("t4_out_count", 32'(got.size() - base), 32'd3);
    if (got.size() >= base + 2) begin
      chk_val("t4_byte0", 32'(got[base]), 32'h20);
      chk_val("t4_byte1", 32'(got[base + 1]), 32'h20);
    end

    // Output back-pressure for 5 cycles mid-stream
    plain_text();
    build_msg(7'h55, 7'h48);
    base = got.size();
    base_in = n_in;
    fork
      run_msg(MSG_LEN);
      begin
        int t;
        t = 0;
        while ((n_in - base_in) < 30 && t < 1000) begin
          @(negedge Clk);
          t++;
        end
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        @(negedge Clk);
        hold = out_data;
        repeat (5) begin
          chk_val("stall_in_ready", 32'(in_ready), 32'd0);
          chk_val("stall_valid", 32'(out_valid), 32'd1);
          chk_val("stall_data", 32'(out_data), 32'(hold));
          @(negedge Clk);
        end
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_out(base + MSG_LEN);
    check_plain(base, MSG_LEN);
    chk_val("t5_no_match", 32'(no_match), 32'd0);
    chk_val("t5_ptrn_idx", 32'(ptrn_idx), 32'd1);

    // Reset mid-message after 30 bytes, then a clean full run
    msg[20] = msg[20] ^ 8'h80;
    msg[40] = msg[40] ^ 8'h80;
    run_msg(30);
    Reset = 1'b0;
    @(negedge Clk);
    chk_val("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    check_cleared("t6");
    @(posedge Clk);
    #1;
    build_msg(7'h55, 7'h48);
    base = got.size();
    run_msg(MSG_LEN);
    wait_out(base + MSG_LEN);
    check_plain(base, MSG_LEN);
    chk_val("t6_ptrn_idx", 32'(ptrn_idx), 32'd1);
    chk_val("t6_seed", 32'(seed), 32'h55);
    chk_val("t6_ack", 32'(Ack), 32'd1);
    chk_val("t6_par_err", 32'(par_err), 32'd0);
    chk_val("t6_err_cnt", 32'(err_cnt), 32'd0);
    chk_val("t6_no_match", 32'(no_match), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
